// File: rtl/noc_input_port.sv
// Router input port: flit FIFO, head decode, wormhole route latch, handshake out.
// Optional NOC_IPORT_ERRDROP_EN: drop packets whose route is an illegal port.
module noc_input_port #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_flit,
    output logic [7:0]        dest_id,
    input  logic [2:0]        switch_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic [2:0]        out_port,
    output logic              pkt_active,
    output logic              err_drop,
    output logic [7:0]        err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE  = 2'd1,
        ACTIVE = 2'd2,
        DROP   = 2'd3
    } state_t;

    state_t state, next_state;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, push, pop;
    logic [FLIT_W-1:0] head_flit;
    logic              is_head, is_tail;
    logic [7:0]        dest_q;
    logic [2:0]        route_q;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full && rst_n;
    assign push      = in_valid && in_ready;
    assign head_flit = mem[rd_ptr];
    // type field: bit0 marks a head, bit1 marks a tail
    assign is_head   = head_flit[FLIT_W-2];
    assign is_tail   = head_flit[FLIT_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_flit;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef NOC_IPORT_ERRDROP_EN
    logic       illegal;
    logic       err_drop_q;
    logic [7:0] err_cnt_q;

    assign illegal = (switch_port >= 3'b101);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_drop_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            err_drop_q <= (state == ROUTE) && illegal;
            if ((state == ROUTE) && illegal && (err_cnt_q != 8'hFF))
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_drop = err_drop_q;
    assign err_cnt  = err_cnt_q;
`else
    assign err_drop = 1'b0;
    assign err_cnt  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dest_q  <= '0;
            route_q <= '0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && (next_state == ROUTE))
                dest_q <= head_flit[7:0];
            if ((state == ROUTE) && (next_state == ACTIVE))
                route_q <= switch_port;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:
                if (!empty && is_head) next_state = ROUTE;
            ROUTE: begin
                next_state = ACTIVE;
`ifdef NOC_IPORT_ERRDROP_EN
                if (illegal) next_state = DROP;
`endif
            end
            ACTIVE:
                if (pop && is_tail) next_state = IDLE;
`ifdef NOC_IPORT_ERRDROP_EN
            DROP:
                if (pop && is_tail) next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE:   pop = !empty && !is_head;
            ACTIVE: begin
                out_valid = !empty;
                pop       = !empty && out_ready;
            end
`ifdef NOC_IPORT_ERRDROP_EN
            DROP:   pop = !empty;
`endif
            default: begin
                out_valid = 1'b0;
                pop       = 1'b0;
            end
        endcase
    end

    assign out_flit   = out_valid ? head_flit : '0;
    assign out_port   = route_q;
    assign dest_id    = dest_q;
    assign pkt_active = (state == ROUTE) || (state == ACTIVE);

endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port: latency, streaming, backpressure,
// stray body flits, mid-packet reset and route handling.
module tb_noc_input_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_flit;
    logic [7:0]  dest_id;
    logic [2:0]  switch_port;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_flit;
    logic [2:0]  out_port;
    logic        pkt_active;
    logic        err_drop;
    logic [7:0]  err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] tx[$];
    logic [31:0] rx[$];
    int          txi;
    logic [31:0] exp4[4];
    logic [31:0] exp6[6];

    noc_input_port #(.FLIT_W(32), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_flit     (in_flit),
        .dest_id     (dest_id),
        .switch_port (switch_port),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_flit    (out_flit),
        .out_port    (out_port),
        .pkt_active  (pkt_active),
        .err_drop    (err_drop),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive inputs, note handshakes that will fire at
    // the coming posedge, then advance to the next negedge.
    task automatic step();
        in_valid = (txi < tx.size());
        in_flit  = in_valid ? tx[txi] : 32'h0;
        #1;
        if (in_valid && in_ready) txi++;
        if (out_valid && out_ready) rx.push_back(out_flit);
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] f);
        tx.push_back(f);
    endtask

    task automatic clear();
        tx.delete();
        rx.delete();
        txi = 0;
    endtask

    task automatic single_pkt(input logic [31:0] f, input logic [2:0] port);
        clear();
        load(f);
        switch_port = port;
        out_ready   = 1'b1;
        step();
        check("sp_idle_valid", {31'b0, out_valid}, 32'd0);
        check("sp_idle_active", {31'b0, pkt_active}, 32'd0);
        step();
        check("sp_route_active", {31'b0, pkt_active}, 32'd1);
        check("sp_route_dest", {24'b0, dest_id}, {24'b0, f[7:0]});
        check("sp_route_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("sp_act_valid", {31'b0, out_valid}, 32'd1);
        check("sp_act_flit", out_flit, f);
        check("sp_act_port", {29'b0, out_port}, {29'b0, port});
        step();
        check("sp_done_active", {31'b0, pkt_active}, 32'd0);
        check("sp_done_valid", {31'b0, out_valid}, 32'd0);
        check("sp_done_flit", out_flit, 32'h0);
        check("sp_rx_count", rx.size(), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_flit     = '0;
        out_ready   = 1'b0;
        switch_port = '0;
        txi         = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_flit", out_flit, 32'h0);
        check("rst_dest_id", {24'b0, dest_id}, 32'h0);
        check("rst_out_port", {29'b0, out_port}, 32'h0);
        check("rst_pkt_active", {31'b0, pkt_active}, 32'd0);
        check("rst_err_drop", {31'b0, err_drop}, 32'd0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Single head+tail flit, dest 0x87, port 000
        single_pkt(32'hC000_1287, 3'b000);

        // Head + 2 body + tail streamed back-to-back on port 100
        clear();
        exp4 = '{32'h4000_AA05, 32'h0000_0B01, 32'h0000_0B02, 32'h8000_0C03};
        for (int i = 0; i < 4; i++) load(exp4[i]);
        switch_port = 3'b100;
        out_ready   = 1'b1;
        step();
        check("s4_idle_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("s4_route_active", {31'b0, pkt_active}, 32'd1);
        check("s4_route_dest", {24'b0, dest_id}, 32'h05);
        step();
        for (int i = 0; i < 4; i++) begin
            check("s4_valid", {31'b0, out_valid}, 32'd1);
            check("s4_flit", out_flit, exp4[i]);
            check("s4_port", {29'b0, out_port}, 32'd4);
            step();
        end
        check("s4_end_active", {31'b0, pkt_active}, 32'd0);
        check("s4_end_valid", {31'b0, out_valid}, 32'd0);

        // 6-flit packet under backpressure fills the FIFO, then drains in order
        clear();
        exp6 = '{32'h4000_0011, 32'h0000_1001, 32'h0000_1002,
                 32'h0000_1003, 32'h0000_1004, 32'h8000_10FF};
        for (int i = 0; i < 6; i++) load(exp6[i]);
        switch_port = 3'b010;
        out_ready   = 1'b0;
        repeat (6) step();
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_pushed", txi, 32'd4);
        check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        check("bp_hold_flit", out_flit, exp6[0]);
        check("bp_port", {29'b0, out_port}, 32'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && rx.size() < 6; c++) step();
        check("bp_rx_count", rx.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < rx.size()) check("bp_rx_flit", rx[i], exp6[i]);
        step();
        check("bp_end_active", {31'b0, pkt_active}, 32'd0);

        // Stray body flit is discarded in IDLE
        clear();
        load(32'h0000_BEEF);
        step();
        check("stray_valid_0", {31'b0, out_valid}, 32'd0);
        step();
        check("stray_valid_1", {31'b0, out_valid}, 32'd0);
        check("stray_active", {31'b0, pkt_active}, 32'd0);
        check("stray_in_ready", {31'b0, in_ready}, 32'd1);
        single_pkt(32'hC000_0042, 3'b011);

        // Reset with two flits buffered mid-packet
        clear();
        load(32'h4000_0033);
        load(32'h0000_2222);
        switch_port = 3'b001;
        out_ready   = 1'b0;
        repeat (3) step();
        check("mr_pre_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", {31'b0, out_valid}, 32'd0);
        check("mr_out_flit", out_flit, 32'h0);
        check("mr_active", {31'b0, pkt_active}, 32'd0);
        check("mr_dest", {24'b0, dest_id}, 32'h0);
        check("mr_port", {29'b0, out_port}, 32'h0);
        check("mr_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        single_pkt(32'hC000_0055, 3'b001);

`ifdef NOC_IPORT_ERRDROP_EN
        // Illegal route drops the whole packet
        clear();
        load(32'h4000_0066);
        load(32'h0000_3001);
        load(32'h8000_3002);
        switch_port = 3'b111;
        out_ready   = 1'b1;
        step();
        step();
        check("drop_route", {31'b0, pkt_active}, 32'd1);
        check("drop_no_pulse", {31'b0, err_drop}, 32'd0);
        step();
        check("drop_pulse", {31'b0, err_drop}, 32'd1);
        check("drop_cnt", {24'b0, err_cnt}, 32'd1);
        check("drop_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("drop_pulse_end", {31'b0, err_drop}, 32'd0);
        repeat (4) step();
        check("drop_rx_none", rx.size(), 32'd0);
        check("drop_cnt_hold", {24'b0, err_cnt}, 32'd1);
        single_pkt(32'hC000_0044, 3'b001);
`else
        // Without the drop feature any port is forwarded as-is
        single_pkt(32'hC000_0077, 3'b111);
        check("nodrop_err_drop", {31'b0, err_drop}, 32'd0);
        check("nodrop_err_cnt", {24'b0, err_cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
